// File: rtl/lab2_truth_table_checker.sv
// Stimulus generator and response checker for two-input lab gates: walks {w,x}
// through all four vectors, samples y after a settle window and scores it.
module lab2_truth_table_checker #(
    parameter int unsigned SETTLE = 2,
    parameter logic [3:0]  EXPECT = 4'b1110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       w,
    output logic       x,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // SETTLE is expected in 1..15 so it fits the 4-bit settle counter.
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    logic [1:0] state_r;
    logic [1:0] idx_r;
    logic [3:0] cnt_r;

    logic [1:0] state_s;
    logic [1:0] idx_s;
    logic [3:0] cnt_s;
    logic [1:0] wx_s;
    logic       busy_s;
    logic       done_s;
    logic       pass_s;
    logic [2:0] err_s;
    logic [3:0] fail_s;
    logic       mismatch_s;
    logic [2:0] err_next_s;

    // Next-state and next-output logic for the run sequencer.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        wx_s       = {w, x};
        busy_s     = busy;
        done_s     = 1'b0;
        pass_s     = pass;
        err_s      = err_count;
        fail_s     = fail_vec;
        mismatch_s = (y != EXPECT[idx_r]);
        err_next_s = err_count + {2'b00, mismatch_s};

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    idx_s   = 2'd0;
                    wx_s    = 2'b00;
                    cnt_s   = SETTLE_CNT;
                    err_s   = 3'd0;
                    fail_s  = 4'b0000;
                    pass_s  = 1'b0;
                    busy_s  = 1'b1;
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                err_s = err_next_s;
                if (mismatch_s) begin
                    fail_s = fail_vec | (4'b0001 << idx_r);
                end else begin
                    fail_s = fail_vec;
                end
                // pass is resolved here so it is already valid during the done pulse.
                if (idx_r == 2'd3) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_next_s == 3'd0);
                    state_s = ST_DONE;
                end else begin
                    idx_s   = idx_r + 2'd1;
                    wx_s    = idx_r + 2'd1;
                    cnt_s   = SETTLE_CNT;
                    state_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns everything to the idle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= 2'd0;
            cnt_r     <= 4'd0;
            w         <= 1'b0;
            x         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'b0000;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
            w         <= wx_s[1];
            x         <= wx_s[0];
            busy      <= busy_s;
            done      <= done_s;
            pass      <= pass_s;
            err_count <= err_s;
            fail_vec  <= fail_s;
        end
    end

endmodule

// File: tb/tb_lab2_truth_table_checker.sv
// Bench for lab2_truth_table_checker: an OR-configured and an XOR-configured
// instance, each tracked cycle by cycle against a run-timeline model.
module tb_lab2_truth_table_checker;

    typedef struct {
        logic [1:0] wx;
        logic       busy;
        logic       done;
        logic       pass;
        int         errs;
        logic [3:0] fv;
        logic       active;
        int         k;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       y_a, y_b;
    logic       rnd_a = 1'b0, rnd_b = 1'b0;
    int         mode_a = 0, mode_b = 0;
    logic       w_a, x_a, busy_a, done_a, pass_a;
    logic       w_b, x_b, busy_b, done_b, pass_b;
    logic [2:0] err_a, err_b;
    logic [3:0] fv_a, fv_b;
    logic       chk_en = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;
    mdl_t       ma = '{default: '0};
    mdl_t       mb = '{default: '0};

    always #5 clk = ~clk;

    // Gate under test: 0 correct, 1 tied low, 2 inverted, 3 random bit.
    assign y_a = (mode_a == 0) ? (w_a | x_a) : (mode_a == 1) ? 1'b0 :
                 (mode_a == 2) ? ~(w_a | x_a) : rnd_a;
    assign y_b = (mode_b == 0) ? (w_b ^ x_b) : (mode_b == 1) ? 1'b0 :
                 (mode_b == 2) ? ~(w_b ^ x_b) : rnd_b;

    lab2_truth_table_checker dut_a (
        .clk(clk), .rst(rst), .start(start_a), .y(y_a),
        .w(w_a), .x(x_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_vec(fv_a)
    );

    lab2_truth_table_checker #(.SETTLE(1), .EXPECT(4'b0110)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .y(y_b),
        .w(w_b), .x(x_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_vec(fv_b)
    );

    // k counts edges since acceptance; a run spans 4*(s+1) edges then one DONE cycle.
    function automatic mdl_t step(input mdl_t m, input int s, input logic [3:0] e,
                                  input logic r, input logic st, input logic yy);
        mdl_t n;
        int   len;
        int   i;
        n   = m;
        len = 4 * (s + 1);
        if (r) begin
            n = '{default: '0};
        end else if (m.active) begin
            if (m.k == len) begin
                n.active = 1'b0;
                n.done   = 1'b0;
            end else begin
                if ((m.k + 1) % (s + 1) == 0) begin
                    i = (m.k + 1) / (s + 1) - 1;
                    if (yy !== e[i]) begin
                        n.errs  = n.errs + 1;
                        n.fv[i] = 1'b1;
                    end
                end
                n.k = m.k + 1;
                if (n.k == len) begin
                    n.busy = 1'b0;
                    n.done = 1'b1;
                    n.pass = (n.errs == 0);
                end else begin
                    n.wx = 2'(n.k / (s + 1));
                end
            end
        end else if (st) begin
            n.active = 1'b1;
            n.k      = 0;
            n.wx     = 2'b00;
            n.errs   = 0;
            n.fv     = 4'b0000;
            n.pass   = 1'b0;
            n.busy   = 1'b1;
            n.done   = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [11:0] pack(input mdl_t m);
        return {m.wx, m.busy, m.done, m.pass, 3'(m.errs), m.fv};
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        ma <= step(ma, 2, 4'b1110, rst, start_a, y_a);
        mb <= step(mb, 1, 4'b0110, rst, start_b, y_b);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("outs_a", {w_a, x_a, busy_a, done_a, pass_a, err_a, fv_a}, pack(ma));
            chk("outs_b", {w_b, x_b, busy_b, done_b, pass_b, err_b, fv_b}, pack(mb));
        end
    end

    // One pulsed-start run; latency counts edges from acceptance to done.
    task automatic run(input bit sel, input int m, input int exp_lat, input logic [2:0] e_err,
                       input logic [3:0] e_fv, input logic e_pass, input string nm);
        int n;
        if (sel) begin
            mode_b  = m;
            start_b = 1'b1;
        end else begin
            mode_a  = m;
            start_a = 1'b1;
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        n = 0;
        while (!(sel ? done_b : done_a) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 12'(n), 12'(exp_lat));
        if (sel) begin
            chk({nm, "_result"}, 12'({pass_b, err_b, fv_b, w_b, x_b, busy_b}),
                12'({e_pass, e_err, e_fv, 1'b1, 1'b1, 1'b0}));
        end else begin
            chk({nm, "_result"}, 12'({pass_a, err_a, fv_a, w_a, x_a, busy_a}),
                12'({e_pass, e_err, e_fv, 1'b1, 1'b1, 1'b0}));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int low;
        int dones;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {w_a, x_a, busy_a, done_a, pass_a, err_a, fv_a}, 12'h000);
        chk("reset_b", {w_b, x_b, busy_b, done_b, pass_b, err_b, fv_b}, 12'h000);
        rst    = 1'b0;
        chk_en = 1'b1;

        run(1'b0, 0, 12, 3'd0, 4'b0000, 1'b1, "or");
        run(1'b0, 1, 12, 3'd3, 4'b1110, 1'b0, "tied0");
        run(1'b0, 2, 12, 3'd4, 4'b1111, 1'b0, "inverted");
        run(1'b1, 0, 8, 3'd0, 4'b0000, 1'b1, "xor");
        run(1'b1, 2, 8, 3'd4, 4'b1111, 1'b0, "xor_inverted");

        // Start held high across two runs: first run fails, second must clear.
        mode_a  = 1;
        start_a = 1'b1;
        n = 0;
        while (!done_a && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_first_err", 12'(err_a), 12'd3);
        mode_a = 0;
        low = 0;
        while (!busy_a && low < 10) begin
            low++;
            @(posedge clk); #1;
        end
        chk("held_busy_gap", 12'(low), 12'd2);
        chk("held_err_cleared", 12'(err_a), 12'd0);
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_second_pass", 12'({pass_a, err_a, fv_a}), 12'b1_000_0000);
        @(posedge clk); #1;

        // Reset during the CHECK cycle of vector 2.
        mode_a  = 0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("pre_reset_vec2", 12'({w_a, x_a, busy_a}), 12'b101);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_reset_a", {w_a, x_a, busy_a, done_a, pass_a, err_a, fv_a}, 12'h000);
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_a) dones++;
        end
        chk("no_done_after_reset", 12'(dones), 12'd0);
        run(1'b0, 0, 12, 3'd0, 4'b0000, 1'b1, "or_after_reset");

        // Randomized phase: random responses, starts and occasional reset.
        mode_a = 3;
        mode_b = 3;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rnd_a   = 1'($urandom);
            rnd_b   = 1'($urandom);
            start_a = ($urandom_range(0, 3) == 0);
            start_b = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 399) == 0);
        end
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
